// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if
//   Groups the encoder's clear, input-field handshake, output-word handshake
//   and error-reporting signals into one interface.
//   master : program builder / test harness (drives fields, consumes words)
//   slave  : mips_instr_encoder
//   Signals: clr, in_valid/in_ready, in_op/rs/rt/rd/shamt/imm/target,
//            out_valid/out_ready, out_instr, out_addr[ADDR_W], err_illegal, err_cnt[8]
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [7:0]        err_cnt;

  modport master (
    output clr, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
           out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_illegal, err_cnt
  );

  modport slave (
    input  clr, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
           out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_illegal, err_cnt
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Streaming MIPS-I instruction encoder. Instruction fields plus a 5-bit op
//   selector are turned into a 32-bit machine word, tagged with an incrementing
//   word address and queued in a 2-entry output FIFO.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mips_instr_encoder_if.slave (clear, input fields + handshake,
//            output word/address + handshake, illegal-op pulse and counter)
//   Parameters: ADDR_W (address counter width), BASE_ADDR (address after reset/clr)
module mips_instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_instr_encoder_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              rstDone;
  logic [1:0]        fifoCnt;
  logic [31:0]       headInstr;
  logic [ADDR_W-1:0] headAddr;
  logic [31:0]       tailInstr;
  logic [ADDR_W-1:0] tailAddr;
  logic [ADDR_W-1:0] nextAddr;
  logic              errIllegal;
  logic [7:0]        errCnt;

  logic [31:0]       encWord;
  logic              opLegal;
  logic              accept;
  logic              push;
  logic              pop;

  // Ready depends only on registered state and clr, never on out_ready.
  // rstDone keeps in_ready low while reset is asserted.
  assign bus.in_ready    = rstDone && (fifoCnt != 2'd2) && !bus.clr;
  assign bus.out_valid   = (fifoCnt != 2'd0);
  assign bus.out_instr   = headInstr;
  assign bus.out_addr    = headAddr;
  assign bus.err_illegal = errIllegal;
  assign bus.err_cnt     = errCnt;

  assign opLegal = (bus.in_op < 5'd27);
  assign accept  = bus.in_valid && bus.in_ready;
  assign push    = accept && opLegal;
  assign pop     = bus.out_valid && bus.out_ready;

  // Field packing. Only the fields an op actually uses are placed in the word.
  always_comb begin
    encWord = '0;
    case (bus.in_op)
      // add..nor share funct 6'b100_xxx with the low op bits
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7:
        encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 3'b100, bus.in_op[2:0]};
      5'd8:  encWord = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
      5'd9:  encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h04};
      5'd10: encWord = {6'h00, bus.in_rs, 15'd0, 6'h08};
      5'd11: encWord = {6'h00, 20'd0, 6'h0D};
      5'd12: encWord = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd13: encWord = {6'h09, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd14: encWord = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd15: encWord = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd16: encWord = {6'h0E, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd17: encWord = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd18: encWord = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd19: encWord = {6'h20, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd20: encWord = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd21: encWord = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd22: encWord = {6'h06, bus.in_rs, 5'd0, bus.in_imm};
      5'd23: encWord = {6'h07, bus.in_rs, 5'd0, bus.in_imm};
      // bltz/bgez share REGIMM opcode; rt selects the condition
      5'd24: encWord = {6'h01, bus.in_rs, 5'd0, bus.in_imm};
      5'd25: encWord = {6'h01, bus.in_rs, 5'd1, bus.in_imm};
      5'd26: encWord = {6'h02, bus.in_target};
      default: encWord = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstDone    <= 1'b0;
      fifoCnt    <= 2'd0;
      headInstr  <= '0;
      headAddr   <= BASE;
      tailInstr  <= '0;
      tailAddr   <= BASE;
      nextAddr   <= BASE;
      errIllegal <= 1'b0;
      errCnt     <= 8'd0;
    end else begin
      rstDone <= 1'b1;
      if (bus.clr) begin
        fifoCnt    <= 2'd0;
        headInstr  <= '0;
        headAddr   <= BASE;
        nextAddr   <= BASE;
        errIllegal <= 1'b0;
        errCnt     <= 8'd0;
      end else begin
        errIllegal <= accept && !opLegal;
        if (accept && !opLegal && (errCnt != 8'hFF))
          errCnt <= errCnt + 8'd1;

        if (push)
          nextAddr <= nextAddr + 1'b1;

        // push+pop at count 2 cannot occur: in_ready is low when full.
        case ({push, pop})
          2'b10: begin
            if (fifoCnt == 2'd0) begin
              headInstr <= encWord;
              headAddr  <= nextAddr;
            end else begin
              tailInstr <= encWord;
              tailAddr  <= nextAddr;
            end
            fifoCnt <= fifoCnt + 2'd1;
          end
          2'b01: begin
            if (fifoCnt == 2'd2) begin
              headInstr <= tailInstr;
              headAddr  <= tailAddr;
            end
            fifoCnt <= fifoCnt - 2'd1;
          end
          2'b11: begin
            headInstr <= encWord;
            headAddr  <= nextAddr;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
//   Directed-vector bench for mips_instr_encoder: one instance with the default
//   8-bit address counter, one with ADDR_W=2 for wrap, clr and mid-stream reset.
module tb_mips_instr_encoder;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  mips_instr_encoder_if #(.ADDR_W(8)) bus ();
  mips_instr_encoder_if #(.ADDR_W(2)) bus2 ();

  mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_shamt  = sh;
    bus.in_imm    = imm;
    bus.in_target = tgt;
  endtask

  // One word through an empty FIFO with out_ready=1: visible one cycle after accept.
  task automatic pushChk(input string tag, input logic [4:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tgt,
                         input logic [31:0] expInstr, input logic [7:0] expAddr);
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    drive(op, rs, rt, rd, sh, imm, tgt);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".instr"}, bus.out_instr, expInstr);
    chk({tag, ".addr"}, 32'(bus.out_addr), 32'(expAddr));
  endtask

  task automatic push2(input logic [4:0] rd);
    @(negedge clk);
    bus2.in_op     = 5'd0;
    bus2.in_rs     = 5'd1;
    bus2.in_rt     = 5'd2;
    bus2.in_rd     = rd;
    bus2.in_valid  = 1'b1;
    @(negedge clk);
    bus2.in_valid  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[5];
    nChecks = 0;
    nFails  = 0;
    rst_n = 1'b0;
    bus.clr = 1'b0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    bus2.clr = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus2.in_op = 5'd0; bus2.in_rs = 5'd0; bus2.in_rt = 5'd0; bus2.in_rd = 5'd0;
    bus2.in_shamt = 5'd0; bus2.in_imm = 16'd0; bus2.in_target = 26'd0;

    // reset state
    #12;
    chk("rst.inReady", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.inReady1", 32'(bus.in_ready), 32'd1);
    chk("rst.outValid", 32'(bus.out_valid), 32'd0);
    chk("rst.outInstr", bus.out_instr, 32'h0);
    chk("rst.outAddr", 32'(bus.out_addr), 32'd0);
    chk("rst.errIll", 32'(bus.err_illegal), 32'd0);
    chk("rst.errCnt", 32'(bus.err_cnt), 32'd0);

    // encodings; junk in unused fields must not leak
    pushChk("add",   5'd0,  5'd1,  5'd2,  5'd3,  5'd17, 16'hABCD, 26'h3FFFFFF, 32'h00221820, 8'd0);
    pushChk("addi",  5'd12, 5'd0,  5'd8,  5'd31, 5'd31, 16'hFFFF, 26'h155555,  32'h2008FFFF, 8'd1);
    pushChk("bgez",  5'd25, 5'd4,  5'd22, 5'd9,  5'd3,  16'h0003, 26'h2AAAAAA, 32'h04810003, 8'd2);
    pushChk("j",     5'd26, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h08000010, 8'd3);
    pushChk("sll",   5'd8,  5'd7,  5'd2,  5'd5,  5'd4,  16'h1234, 26'h1234567, 32'h00022900, 8'd4);
    pushChk("jr",    5'd10, 5'd31, 5'd13, 5'd21, 5'd6,  16'h5A5A, 26'h2222222, 32'h03E00008, 8'd5);
    pushChk("lw",    5'd17, 5'd29, 5'd9,  5'd7,  5'd7,  16'h0010, 26'h1111111, 32'h8FA90010, 8'd6);
    pushChk("sw",    5'd18, 5'd29, 5'd9,  5'd7,  5'd7,  16'h0004, 26'h1111111, 32'hAFA90004, 8'd7);
    pushChk("break", 5'd11, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000000D, 8'd8);
    pushChk("blez",  5'd22, 5'd3,  5'd7,  5'd1,  5'd1,  16'h0008, 26'h0,       32'h18600008, 8'd9);
    pushChk("nor",   5'd7,  5'd1,  5'd2,  5'd3,  5'd9,  16'hFFFF, 26'h0,       32'h00221827, 8'd10);
    pushChk("bltz",  5'd24, 5'd4,  5'd9,  5'd9,  5'd9,  16'h0003, 26'h0,       32'h04800003, 8'd11);

    // illegal op between two adds
    pushChk("ill.a0", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820, 8'd12);
    @(negedge clk);
    drive(5'd29, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ill.pulse", 32'(bus.err_illegal), 32'd1);
    chk("ill.noEnq", 32'(bus.out_valid), 32'd0);
    chk("ill.cnt", 32'(bus.err_cnt), 32'd1);
    @(negedge clk);
    chk("ill.pulseEnd", 32'(bus.err_illegal), 32'd0);
    pushChk("ill.a1", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820, 8'd13);

    // clr
    @(negedge clk);
    bus.clr = 1'b1;
    #1;
    chk("clr.inReady", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.clr = 1'b0;
    chk("clr.outValid", 32'(bus.out_valid), 32'd0);
    chk("clr.errCnt", 32'(bus.err_cnt), 32'd0);
    chk("clr.outAddr", 32'(bus.out_addr), 32'd0);

    // back-pressure: three pushes with out_ready low
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("bp.full", 32'(bus.in_ready), 32'd0);
    chk("bp.headA", bus.out_instr, 32'h00221820);
    chk("bp.addrA", 32'(bus.out_addr), 32'd0);
    drive(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("bp.stillFull", 32'(bus.in_ready), 32'd0);
    chk("bp.stable", bus.out_instr, 32'h00221820);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.headB", bus.out_instr, 32'h00221822);
    chk("bp.addrB", 32'(bus.out_addr), 32'd1);
    chk("bp.ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.vldC", 32'(bus.out_valid), 32'd1);
    chk("bp.headC", bus.out_instr, 32'h00221825);
    chk("bp.addrC", 32'(bus.out_addr), 32'd2);
    @(negedge clk);
    chk("bp.empty", 32'(bus.out_valid), 32'd0);

    // ADDR_W=2 wrap
    exp2 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      push2(5'(i));
      chk($sformatf("wrap.addr%0d", i), 32'(bus2.out_addr), 32'(exp2[i]));
    end

    // clr mid-stream
    bus2.out_ready = 1'b0;
    push2(5'd1);
    push2(5'd2);
    chk("clr2.full", 32'(bus2.in_ready), 32'd0);
    @(negedge clk);
    bus2.clr = 1'b1;
    @(negedge clk);
    bus2.clr = 1'b0;
    chk("clr2.empty", 32'(bus2.out_valid), 32'd0);
    bus2.out_ready = 1'b1;
    push2(5'd3);
    chk("clr2.addr", 32'(bus2.out_addr), 32'd0);
    chk("clr2.instr", bus2.out_instr, 32'h00221820 | 32'h0);

    // reset mid-stream
    bus2.out_ready = 1'b0;
    push2(5'd3);
    push2(5'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2.empty", 32'(bus2.out_valid), 32'd0);
    chk("rst2.inReady", 32'(bus2.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2.inReady1", 32'(bus2.in_ready), 32'd1);
    chk("rst2.outAddr", 32'(bus2.out_addr), 32'd0);
    bus2.out_ready = 1'b1;
    push2(5'd3);
    chk("rst2.vld", 32'(bus2.out_valid), 32'd1);
    chk("rst2.addr", 32'(bus2.out_addr), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
